// File: rtl/ppu_reg_master.sv
// Queued CPU-side register master for the PPU: one chip-select strobe per request, fixed gap between.
// Define PPU_DMA_EN to build the 256-byte OAM DMA engine (memory page -> OAMDATA writes).
module ppu_reg_master #(
    parameter int CS_CYCLES  = 2,
    parameter int GAP_CYCLES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [2:0]  req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        cpu_cs,
    output logic        cpu_rw,
    output logic [2:0]  cpu_addr,
    output logic [7:0]  cpu_wdata,
    input  logic [7:0]  cpu_rdata,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        dma_busy,
    output logic        dma_mem_rd,
    output logic [15:0] dma_mem_addr,
    input  logic [7:0]  dma_mem_data
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = 1;
    localparam logic [3:0]  CS_LAST  = 4'(CS_CYCLES - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef struct packed {
        logic       rw;
        logic [2:0] addr;
        logic [7:0] data;
    } req_t;

`ifdef PPU_DMA_EN
    typedef enum logic [2:0] {IDLE, STROBE, GAP, DMA_RD, DMA_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, STROBE, GAP} state_t;
`endif

    req_t        fifo_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, push, pop;
    req_t        head;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cpu_rw_q;
    logic [2:0]  cpu_addr_q;
    logic [7:0]  cpu_wdata_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        last_strobe, go_idle, dma_load, dma_blk;

    // Extra pointer bit distinguishes full from empty.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign head        = fifo_q[rd_ptr_q[AW-1:0]];
    assign req_ready   = !fifo_full && !dma_blk;
    assign push        = req_valid && req_ready;
    assign last_strobe = (state_q == STROBE) && (cnt_q == CS_LAST);

    assign cpu_cs    = (state_q == STROBE);
    assign cpu_rw    = cpu_rw_q;
    assign cpu_addr  = cpu_addr_q;
    assign cpu_wdata = cpu_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef PPU_DMA_EN
    logic       dma_busy_q, dma_act_q, dma_next, dma_done;
    logic [7:0] dma_page_q, dma_idx_q;

    assign dma_blk      = dma_busy_q;
    assign dma_busy     = dma_busy_q;
    assign dma_mem_rd   = (state_q == DMA_RD);
    assign dma_mem_addr = {dma_page_q, dma_idx_q};

    // dma_act_q marks that the engine owns the strobe, so the FIFO is not consulted at gap end.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_busy_q <= 1'b0;
            dma_act_q  <= 1'b0;
            dma_page_q <= '0;
            dma_idx_q  <= '0;
        end else begin
            if (dma_start && !dma_busy_q) begin
                dma_busy_q <= 1'b1;
                dma_page_q <= dma_page;
                dma_idx_q  <= '0;
            end
            if (state_d == DMA_RD) dma_act_q <= 1'b1;
            if (dma_next) dma_idx_q <= dma_idx_q + 8'd1;
            if (dma_done) begin
                dma_busy_q <= 1'b0;
                dma_act_q  <= 1'b0;
            end
        end
    end
`else
    logic dma_unused;
    assign dma_unused   = ^{dma_start, dma_page};
    assign dma_blk      = 1'b0;
    assign dma_busy     = 1'b0;
    assign dma_mem_rd   = 1'b0;
    assign dma_mem_addr = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        go_idle  = 1'b0;
        dma_load = 1'b0;
`ifdef PPU_DMA_EN
        dma_next = 1'b0;
        dma_done = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = STROBE;
                    pop     = 1'b1;
                    cnt_d   = '0;
                end
`ifdef PPU_DMA_EN
                else if (dma_busy_q) state_d = DMA_RD;
`endif
            end
            STROBE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CS_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    go_idle = 1'b1;
`ifdef PPU_DMA_EN
                    if (dma_act_q) begin
                        if (dma_idx_q == 8'hFF) dma_done = 1'b1;
                        else begin
                            state_d  = DMA_RD;
                            go_idle  = 1'b0;
                            dma_next = 1'b1;
                        end
                    end else
`endif
                    if (!fifo_empty) begin
                        state_d = STROBE;
                        pop     = 1'b1;
                        go_idle = 1'b0;
                    end
`ifdef PPU_DMA_EN
                    else if (dma_busy_q) begin
                        state_d = DMA_RD;
                        go_idle = 1'b0;
                    end
`endif
                end
            end
`ifdef PPU_DMA_EN
            DMA_RD: state_d = DMA_WAIT;
            DMA_WAIT: begin
                state_d  = STROBE;
                cnt_d    = '0;
                dma_load = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cpu_rw_q    <= 1'b1;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                {cpu_rw_q, cpu_addr_q, cpu_wdata_q} <= head;
            end else if (dma_load) begin
                cpu_rw_q    <= 1'b0;
                cpu_addr_q  <= 3'd4;
                cpu_wdata_q <= dma_mem_data;
            end else if (go_idle) begin
                cpu_rw_q <= 1'b1;
            end
            // PPU read data has settled by the last strobe cycle.
            rsp_valid_q <= last_strobe && cpu_rw_q;
            if (last_strobe && cpu_rw_q) rsp_data_q <= cpu_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= {req_rw, req_addr, req_data};
    end
endmodule

// File: tb/tb_ppu_reg_master.sv
// Scoreboard bench for ppu_reg_master: stimulus pushes expected PPU accesses/responses, monitors pop and compare.
module tb_ppu_reg_master;
    localparam int CS  = 2;
    localparam int GAP = 1;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_rw = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        req_ready, rsp_valid, cpu_cs, cpu_rw;
    logic [7:0]  rsp_data, cpu_wdata;
    logic [2:0]  cpu_addr;
    logic [7:0]  cpu_rdata = '0;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_page = '0;
    logic        dma_busy, dma_mem_rd;
    logic [15:0] dma_mem_addr;
    logic [7:0]  dma_mem_data = '0;

    ppu_reg_master #(.CS_CYCLES(CS), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .dma_start(dma_start), .dma_page(dma_page), .dma_busy(dma_busy),
        .dma_mem_rd(dma_mem_rd), .dma_mem_addr(dma_mem_addr), .dma_mem_data(dma_mem_data));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       rw;
        logic [2:0] addr;
        logic [7:0] data;
    } acc_t;

    acc_t       exp_acc[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] model_regs[8];
    logic [7:0] ppu_regs[8];
    int total = 0, bad = 0;

    function automatic logic [7:0] init_val(int i);
        return (i == 2) ? 8'hE0 : 8'(i * 17 + 3);
    endfunction

    function automatic logic [7:0] mem_f(logic [15:0] a);
        return 8'(a[7:0] * 8'd3) + a[15:8];
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // PPU: acts on cs rising edge; read data registered, valid the cycle after cs rises.
    logic cs_d1 = 1'b0;
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 8; i++) ppu_regs[i] <= init_val(i);
        end else begin
            if (cpu_cs && !cs_d1 && !cpu_rw) ppu_regs[cpu_addr] <= cpu_wdata;
            if (cpu_cs) cpu_rdata <= ppu_regs[cpu_addr];
        end
        cs_d1 <= cpu_cs;
    end

    // DMA source memory: data one cycle after the read strobe.
    always @(posedge clk) if (dma_mem_rd) dma_mem_data <= mem_f(dma_mem_addr);

    // Monitors
    int   high_run = 0, low_run = 1000, nstrobe = 0, nrsp = 0, rise_cyc = 0, rsp_cyc = 0;
    int   dma_i = 0;
    logic [7:0] dma_pg_exp = '0;
    logic prev_cs = 1'b0, ready_low_seen = 1'b0;
    acc_t cur = '0, e;
    logic [7:0] er;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs  = 1'b0;
            high_run = 0;
            low_run  = 1000;
        end else begin
            if (!req_ready) ready_low_seen = 1'b1;
            if (cpu_cs) begin
                if (!prev_cs) begin
                    nstrobe++;
                    rise_cyc = cyc;
                    chk("gap_before_strobe", (low_run >= GAP) ? 1 : 0, 1);
                    cur = {cpu_rw, cpu_addr, cpu_wdata};
                    if (exp_acc.size() == 0) chk("unexpected_strobe", int'(cur), -1);
                    else begin
                        e = exp_acc.pop_front();
                        chk("strobe_access", int'(cur), int'(e));
                    end
                    high_run = 0;
                end else begin
                    chk("hold_while_cs", int'({cpu_rw, cpu_addr, cpu_wdata}), int'(cur));
                end
                high_run++;
            end else begin
                if (prev_cs) begin
                    chk("cs_width", high_run, CS);
                    low_run = 0;
                end
                low_run++;
                if (low_run <= GAP) chk("hold_in_gap", int'({cpu_rw, cpu_addr, cpu_wdata}), int'(cur));
                else if (!dma_busy) chk("rw_idle", int'(cpu_rw), 1);
            end
            if (rsp_valid) begin
                nrsp++;
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) chk("unexpected_rsp", int'(rsp_data), -1);
                else begin
                    er = exp_rsp.pop_front();
                    chk("rsp_data", int'(rsp_data), int'(er));
                end
            end
            if (dma_mem_rd) begin
                chk("dma_mem_addr", int'(dma_mem_addr), int'({dma_pg_exp, 8'(dma_i)}));
                dma_i++;
            end
            prev_cs = cpu_cs;
        end
    end

    task automatic send(input logic rw, input logic [2:0] a, input logic [7:0] d, output int acc_cyc);
        logic ok;
        ok        = 1'b0;
        acc_cyc   = -1;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_data  = d;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready;
            if (ok) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
        else begin
            exp_acc.push_back(acc_t'({rw, a, d}));
            if (rw) exp_rsp.push_back(model_regs[a]);
            else model_regs[a] = d;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (n < 4000 && (exp_acc.size() != 0 || exp_rsp.size() != 0 || cpu_cs || dma_busy)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 4000) chk("drain_timeout", n, 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        int acc, n0, r0, n;
        for (int i = 0; i < 8; i++) model_regs[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_cpu_cs", int'(cpu_cs), 0);
        chk("rst_cpu_rw", int'(cpu_rw), 1);
        chk("rst_cpu_addr", int'(cpu_addr), 0);
        chk("rst_cpu_wdata", int'(cpu_wdata), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_dma_busy", int'(dma_busy), 0);
        chk("rst_dma_mem_rd", int'(dma_mem_rd), 0);
        chk("rst_dma_mem_addr", int'(dma_mem_addr), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        repeat (3) begin @(posedge clk); #1; end

        // Single write: latency from acceptance to cs rise.
        send(1'b0, 3'd0, 8'h80, acc);
        wait_drain();
        chk("write_cs_latency", rise_cyc - acc, 2);

        // Single read of reg 2.
        r0 = nrsp;
        send(1'b1, 3'd2, 8'h55, acc);
        wait_drain();
        chk("read_rsp_latency", rsp_cyc - acc, 4);
        chk("read_rsp_count", nrsp - r0, 1);

        // Six back-to-back writes overflow the 4-entry FIFO.
        ready_low_seen = 1'b0;
        n0 = nstrobe;
        for (int k = 0; k < 6; k++) send(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), acc);
        wait_drain();
        chk("ready_dropped", int'(ready_low_seen), 1);
        chk("six_strobes", nstrobe - n0, 6);

        send(1'b0, 3'd6, 8'h3F, acc);
        send(1'b0, 3'd6, 8'h00, acc);
        send(1'b0, 3'd7, 8'h0F, acc);
        wait_drain();

        // Random mix of reads and writes with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), acc);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_drain();

        // Reset in the middle of a queued read strobe.
        send(1'b1, 3'($urandom_range(0, 7)), 8'h00, acc);
        send(1'b1, 3'd1, 8'h00, acc);
        send(1'b1, 3'd3, 8'h00, acc);
        n = 0;
        while (!cpu_cs && n < 50) begin @(posedge clk); #1; n++; end
        chk("strobe_before_rst", int'(cpu_cs), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_drops_cs", int'(cpu_cs), 0);
        exp_acc.delete();
        exp_rsp.delete();
        n0 = nstrobe;
        r0 = nrsp;
        repeat (20) begin @(posedge clk); #1; end
        chk("no_strobe_after_rst", nstrobe - n0, 0);
        chk("no_rsp_after_rst", nrsp - r0, 0);
        chk("rst2_rsp_data", int'(rsp_data), 0);
        chk("rst2_req_ready", int'(req_ready), 1);

`ifdef PPU_DMA_EN
        send(1'b0, 3'd5, 8'hA7, acc);
        dma_pg_exp = 8'h02;
        dma_i      = 0;
        for (int i = 0; i < 256; i++) exp_acc.push_back(acc_t'({1'b0, 3'd4, mem_f({8'h02, 8'(i)})}));
        model_regs[4] = mem_f(16'h02FF);
        dma_page  = 8'h02;
        dma_start = 1'b1;
        @(posedge clk);
        #1;
        dma_start = 1'b0;
        chk("dma_busy_set", int'(dma_busy), 1);
        chk("dma_blocks_req", int'(req_ready), 0);
        wait_drain();
        chk("dma_reads", dma_i, 256);
        chk("dma_busy_clear", int'(dma_busy), 0);
        chk("dma_ready_back", int'(req_ready), 1);
`else
        dma_page  = 8'h02;
        dma_start = 1'b1;
        @(posedge clk);
        #1;
        dma_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("nodma_busy", int'(dma_busy), 0);
            chk("nodma_rd", int'(dma_mem_rd), 0);
            chk("nodma_addr", int'(dma_mem_addr), 0);
            chk("nodma_ready", int'(req_ready), 1);
            @(posedge clk);
            #1;
        end
`endif
        // Confirm PPU state reflects the write history via a read-back of every register.
        for (int i = 0; i < 8; i++) send(1'b1, 3'(i), 8'h00, acc);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
